// File: rtl/pwr_seq_ctrl.sv
// Ordered power-rail sequencer: one shared tick timer for per-rail on/off delays and power-good timeouts.
// Optional PWR_SEQ_PG_DEGLITCH_EN: 3-clk low filter on pg_in loss detection.
module pwr_seq_ctrl #(
  parameter int unsigned NUM_RAILS = 4,
  parameter int unsigned CNTR_NBITS = 8,
  parameter logic [CNTR_NBITS-1:0] PG_TIMEOUT = CNTR_NBITS'(200)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            tick,
  input  logic                            pwr_on_req,
  input  logic [NUM_RAILS*CNTR_NBITS-1:0] dly_cfg,
  input  logic [NUM_RAILS-1:0]            pg_in,
  output logic [NUM_RAILS-1:0]            rail_en,
  output logic                            seq_done,
  output logic                            fault,
  output logic [3:0]                      fault_rail,
  output logic [2:0]                      state_o
);

  localparam int unsigned IDX_W = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RAILS - 1);
  localparam logic [CNTR_NBITS-1:0] TIMER_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UP_DLY = 3'd1,
    S_UP_PG  = 3'd2,
    S_ON     = 3'd3,
    S_DN_DLY = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [CNTR_NBITS-1:0]   timer;
  logic [NUM_RAILS-1:0]    rail_en_nxt;
  logic [3:0]              fault_rail_nxt;
  logic [CNTR_NBITS-1:0]   dly_arr [NUM_RAILS];
  logic [NUM_RAILS-1:0]    pg_ok;
  logic [NUM_RAILS-1:0]    lost_mask;
  logic [NUM_RAILS-1:0]    pg_lost;
  logic                    lost_any;
  logic [3:0]              lost_idx;
  logic                    dly_hit;
  logic                    pg_timeout;

  for (genvar g = 0; g < NUM_RAILS; g++) begin : g_dly
    assign dly_arr[g] = dly_cfg[g*CNTR_NBITS +: CNTR_NBITS];
  end

`ifdef PWR_SEQ_PG_DEGLITCH_EN
  // A rail is lost only once pg_in has been low for three consecutive clocks.
  logic [NUM_RAILS-1:0] pg_d1, pg_d2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pg_d1 <= '0;
      pg_d2 <= '0;
    end else begin
      pg_d1 <= pg_in;
      pg_d2 <= pg_d1;
    end
  end

  assign pg_ok = pg_in | pg_d1 | pg_d2;
`else
  assign pg_ok = pg_in;
`endif

  // Rails watched for power-good loss: all of them in ON, those below idx in UP_PG.
  always_comb begin
    lost_mask = '0;
    for (int i = 0; i < int'(NUM_RAILS); i++) begin
      if (state == S_ON || (state == S_UP_PG && IDX_W'(i) < idx)) begin
        lost_mask[i] = 1'b1;
      end
    end
  end

  assign pg_lost  = ~pg_ok & lost_mask;
  assign lost_any = |pg_lost;

  always_comb begin
    lost_idx = '0;
    for (int i = int'(NUM_RAILS) - 1; i >= 0; i--) begin
      if (pg_lost[i]) begin
        lost_idx = 4'(i);
      end
    end
  end

  assign dly_hit    = tick && (timer == dly_arr[idx]);
  assign pg_timeout = tick && (timer == PG_TIMEOUT) && !pg_in[idx];

  // Next-state, next-index and next-output decode.
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    rail_en_nxt    = rail_en;
    fault_rail_nxt = fault_rail;

    case (state)
      S_IDLE: begin
        if (pwr_on_req) begin
          idx_nxt   = '0;
          state_nxt = S_UP_DLY;
        end
      end

      S_UP_DLY: begin
        if (!pwr_on_req) begin
          if (idx == '0) begin
            state_nxt = S_IDLE;
          end else begin
            idx_nxt   = idx - IDX_W'(1);
            state_nxt = S_DN_DLY;
          end
        end else if (dly_hit) begin
          rail_en_nxt[idx] = 1'b1;
          state_nxt        = S_UP_PG;
        end
      end

      S_UP_PG: begin
        if (lost_any) begin
          fault_rail_nxt = lost_idx;
          state_nxt      = S_FAULT;
        end else if (pg_timeout) begin
          fault_rail_nxt = 4'(idx);
          state_nxt      = S_FAULT;
        end else if (!pwr_on_req) begin
          state_nxt = S_DN_DLY;
        end else if (pg_in[idx]) begin
          if (idx == LAST_IDX) begin
            state_nxt = S_ON;
          end else begin
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = S_UP_DLY;
          end
        end
      end

      S_ON: begin
        if (lost_any) begin
          fault_rail_nxt = lost_idx;
          state_nxt      = S_FAULT;
        end else if (!pwr_on_req) begin
          idx_nxt   = LAST_IDX;
          state_nxt = S_DN_DLY;
        end
      end

      S_DN_DLY: begin
        if (dly_hit) begin
          rail_en_nxt[idx] = 1'b0;
          if (idx == '0) begin
            state_nxt = S_IDLE;
          end else begin
            idx_nxt = idx - IDX_W'(1);
          end
        end
      end

      S_FAULT: begin
        if (!pwr_on_req) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // FAULT and IDLE never hold any rail enabled.
    if (state_nxt == S_FAULT || state_nxt == S_IDLE) begin
      rail_en_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      timer      <= '0;
      rail_en    <= '0;
      seq_done   <= 1'b0;
      fault      <= 1'b0;
      fault_rail <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      rail_en    <= rail_en_nxt;
      seq_done   <= (state_nxt == S_ON);
      fault      <= (state_nxt == S_FAULT);
      fault_rail <= fault_rail_nxt;
      if ((state_nxt != state) || (idx_nxt != idx)) begin
        timer <= '0;
      end else if (tick && (timer != TIMER_MAX)) begin
        timer <= timer + CNTR_NBITS'(1);
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Directed bench for pwr_seq_ctrl: sequencing order, tick delays, pg timeout, pg loss, abort and reset.
module tb_pwr_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick = 1'b0;
  logic        pwr_on_req;
  logic [31:0] dly_cfg;
  logic [3:0]  pg_in;
  logic [3:0]  rail_en;
  logic        seq_done;
  logic        fault;
  logic [3:0]  fault_rail;
  logic [2:0]  state_o;

  logic [3:0]  pg_low;
  logic [3:0]  prev_en = 4'b0;
  logic [3:0]  seen = 4'b0;
  int          tick_period = 4;
  int          tick_div = 0;
  int          tick_total = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  pwr_seq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .pwr_on_req (pwr_on_req),
    .dly_cfg    (dly_cfg),
    .pg_in      (pg_in),
    .rail_en    (rail_en),
    .seq_done   (seq_done),
    .fault      (fault),
    .fault_rail (fault_rail),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  // Rail model: pg rises once a tick has passed with the rail enabled; pg_low forces it low.
  always @(negedge clk) begin
    prev_en <= rail_en;
    seen    <= rail_en & (seen | (prev_en & {4{tick}}));
    if (tick_div >= tick_period - 1) begin
      tick_div <= 0;
      tick     <= 1'b1;
    end else begin
      tick_div <= tick_div + 1;
      tick     <= 1'b0;
    end
  end

  assign pg_in = seen & rail_en & ~pg_low;

  always @(posedge clk) begin
    if (tick) tick_total <= tick_total + 1;
  end

  task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
    for (int i = 0; i < budget; i++) begin
      if (state_o === s) break;
      @(negedge clk);
    end
    ok = (state_o === s);
  endtask

  task automatic wait_en_change(input logic [3:0] from, input int budget, output bit ok);
    for (int i = 0; i < budget; i++) begin
      if (rail_en !== from) break;
      @(negedge clk);
    end
    ok = (rail_en !== from);
  endtask

  task automatic wait_en_value(input logic [3:0] v, input int budget, output bit ok);
    for (int i = 0; i < budget; i++) begin
      if (rail_en === v) break;
      @(negedge clk);
    end
    ok = (rail_en === v);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    n_checks++;
    if (rail_en !== 4'b0000) begin n_fail++; $display("FAIL reset_rail_en: got %b expected 0000", rail_en); end
    n_checks++;
    if ({seq_done, fault, fault_rail} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got done=%b fault=%b rail=%0d expected 0 0 0", seq_done, fault, fault_rail);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (state_o !== 3'd0) begin n_fail++; $display("FAIL idle_after_reset: got %0d expected 0", state_o); end
  endtask

  task automatic test_power_up();
    logic [3:0] exp_en;
    bit ok;
    int t0;
    dly_cfg = {4{8'd2}};
    tick_period = 4;
    pwr_on_req = 1'b1;
    exp_en = 4'b0000;
    for (int r = 0; r < 4; r++) begin
      wait_state(3'd1, 200, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL up_dly_entry rail %0d: got state %0d expected 1", r, state_o); end
      t0 = tick_total;
      wait_en_change(exp_en, 200, ok);
      exp_en[r] = 1'b1;
      n_checks++;
      if (rail_en !== exp_en) begin n_fail++; $display("FAIL up_en_step rail %0d: got %b expected %b", r, rail_en, exp_en); end
      n_checks++;
      if (tick_total - t0 != 3) begin n_fail++; $display("FAIL up_en_ticks rail %0d: got %0d expected 3", r, tick_total - t0); end
    end
    wait_state(3'd3, 200, ok);
    n_checks++;
    if (!ok || seq_done !== 1'b1 || fault !== 1'b0) begin
      n_fail++; $display("FAIL on_reached: got state=%0d done=%b fault=%b expected 3 1 0", state_o, seq_done, fault);
    end
  endtask

  task automatic test_power_down();
    logic [3:0] exp_en;
    bit ok;
    int t0;
    pwr_on_req = 1'b0;
    exp_en = 4'b1111;
    wait_state(3'd4, 10, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL dn_entry: got state %0d expected 4", state_o); end
    t0 = tick_total;
    for (int r = 3; r >= 0; r--) begin
      wait_en_change(exp_en, 200, ok);
      exp_en[r] = 1'b0;
      n_checks++;
      if (rail_en !== exp_en) begin n_fail++; $display("FAIL dn_en_step rail %0d: got %b expected %b", r, rail_en, exp_en); end
      n_checks++;
      if (tick_total - t0 != 3) begin n_fail++; $display("FAIL dn_en_ticks rail %0d: got %0d expected 3", r, tick_total - t0); end
      t0 = tick_total;
    end
    n_checks++;
    if (state_o !== 3'd0 || seq_done !== 1'b0) begin
      n_fail++; $display("FAIL dn_idle: got state=%0d done=%b expected 0 0", state_o, seq_done);
    end
  endtask

  task automatic test_pg_timeout();
    bit ok;
    int t0;
    pg_low = 4'b0100;
    pwr_on_req = 1'b1;
    wait_en_value(4'b0111, 300, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL to_rail2_en: got %b expected 0111", rail_en); end
    t0 = tick_total;
    wait_state(3'd5, 1500, ok);
    // 200 ticks are counted in UP_PG; the fault is taken on the tick after them.
    n_checks++;
    if (!ok || tick_total - t0 != 201) begin
      n_fail++; $display("FAIL to_ticks: got state=%0d ticks=%0d expected 5 201", state_o, tick_total - t0);
    end
    n_checks++;
    if (rail_en !== 4'b0000 || fault !== 1'b1 || fault_rail !== 4'd2) begin
      n_fail++; $display("FAIL to_fault: got en=%b fault=%b rail=%0d expected 0000 1 2", rail_en, fault, fault_rail);
    end
    pwr_on_req = 1'b0;
    pg_low = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (state_o !== 3'd0 || fault !== 1'b0 || fault_rail !== 4'd2) begin
      n_fail++; $display("FAIL to_clear: got state=%0d fault=%b rail=%0d expected 0 0 2", state_o, fault, fault_rail);
    end
  endtask

  task automatic test_pg_glitch();
    bit ok;
    dly_cfg = 32'd0;
    tick_period = 1;
    @(negedge clk);
    pwr_on_req = 1'b1;
    wait_state(3'd3, 100, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL gl_on: got state %0d expected 3", state_o); end
    pg_low = 4'b0010;
    @(negedge clk);
    pg_low = 4'b0000;
`ifdef PWR_SEQ_PG_DEGLITCH_EN
    repeat (4) @(negedge clk);
    n_checks++;
    if (state_o !== 3'd3) begin n_fail++; $display("FAIL gl_short_filtered: got state %0d expected 3", state_o); end
    pg_low = 4'b0010;
    repeat (2) @(negedge clk);
    n_checks++;
    if (state_o !== 3'd3) begin n_fail++; $display("FAIL gl_two_clk_filtered: got state %0d expected 3", state_o); end
    @(negedge clk);
    pg_low = 4'b0000;
`endif
    n_checks++;
    if (state_o !== 3'd5 || fault_rail !== 4'd1 || rail_en !== 4'b0000) begin
      n_fail++; $display("FAIL gl_fault: got state=%0d rail=%0d en=%b expected 5 1 0000", state_o, fault_rail, rail_en);
    end
    pwr_on_req = 1'b0;
    wait_state(3'd0, 10, ok);
    n_checks++;
    if (!ok || fault !== 1'b0) begin n_fail++; $display("FAIL gl_clear: got state=%0d fault=%b expected 0 0", state_o, fault); end
  endtask

  task automatic test_multi_drop();
    bit ok;
    pwr_on_req = 1'b1;
    wait_state(3'd3, 100, ok);
    pg_low = 4'b1100;
    wait_state(3'd5, 6, ok);
    n_checks++;
    if (!ok || fault_rail !== 4'd2) begin
      n_fail++; $display("FAIL multi_lowest: got state=%0d rail=%0d expected 5 2", state_o, fault_rail);
    end
    pg_low = 4'b0000;
    pwr_on_req = 1'b0;
    wait_state(3'd0, 10, ok);
  endtask

  task automatic test_abort_up();
    bit ok;
    int t0;
    dly_cfg = {4{8'd2}};
    tick_period = 4;
    pwr_on_req = 1'b1;
    wait_en_value(4'b0011, 300, ok);
    wait_state(3'd1, 50, ok);
    n_checks++;
    if (!ok || rail_en !== 4'b0011) begin n_fail++; $display("FAIL ab_up_dly2: got state=%0d en=%b expected 1 0011", state_o, rail_en); end
    pwr_on_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (state_o !== 3'd4 || rail_en !== 4'b0011) begin
      n_fail++; $display("FAIL ab_dn_entry: got state=%0d en=%b expected 4 0011", state_o, rail_en);
    end
    t0 = tick_total;
    pwr_on_req = 1'b1;
    wait_en_change(4'b0011, 200, ok);
    n_checks++;
    if (rail_en !== 4'b0001 || tick_total - t0 != 3) begin
      n_fail++; $display("FAIL ab_rail1_off: got en=%b ticks=%0d expected 0001 3", rail_en, tick_total - t0);
    end
    t0 = tick_total;
    wait_en_change(4'b0001, 200, ok);
    n_checks++;
    if (rail_en !== 4'b0000 || state_o !== 3'd0 || tick_total - t0 != 3) begin
      n_fail++; $display("FAIL ab_rail0_off: got en=%b state=%0d ticks=%0d expected 0000 0 3", rail_en, state_o, tick_total - t0);
    end
    @(negedge clk);
    n_checks++;
    if (state_o !== 3'd1) begin n_fail++; $display("FAIL ab_restart: got state %0d expected 1", state_o); end
    wait_en_value(4'b0001, 100, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ab_restart_rail0: got %b expected 0001", rail_en); end
    pwr_on_req = 1'b0;
    wait_state(3'd0, 200, ok);
    n_checks++;
    if (!ok || rail_en !== 4'b0000) begin n_fail++; $display("FAIL ab_final_idle: got state=%0d en=%b expected 0 0000", state_o, rail_en); end
  endtask

  task automatic test_zero_delay_reset();
    dly_cfg = 32'd0;
    tick_period = 1;
    pg_low = 4'b1111;
    @(negedge clk);
    pwr_on_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if (state_o !== 3'd1 || rail_en !== 4'b0000) begin
      n_fail++; $display("FAIL zd_entry: got state=%0d en=%b expected 1 0000", state_o, rail_en);
    end
    @(negedge clk);
    n_checks++;
    if (state_o !== 3'd2 || rail_en !== 4'b0001) begin
      n_fail++; $display("FAIL zd_enable: got state=%0d en=%b expected 2 0001", state_o, rail_en);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (rail_en !== 4'b0000 || state_o !== 3'd0 || seq_done !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got en=%b state=%0d done=%b expected 0000 0 0", rail_en, state_o, seq_done);
    end
    pwr_on_req = 1'b0;
    pg_low = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    pwr_on_req = 1'b0;
    dly_cfg = {4{8'd2}};
    pg_low = 4'b0000;
    test_reset();
    test_power_up();
    test_power_down();
    test_pg_timeout();
    test_pg_glitch();
    test_multi_drop();
    test_abort_up();
    test_zero_delay_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
